hoop_controller: RTL

- Upstream stage of the hoops bitmap.
- Owns one hoop's lifecycle: spawn delay, spawn at the right screen edge at a clamped random Y, leftward motion once per frame, one-shot pass detection, and despawn off the left edge.
- Each pixel clock it converts pixelX/pixelY into registered offsetX/offsetY/insideRectangle for the bitmap.
- Reports hoopPassed to the score logic.

---
 rtl/hoops_pkg.sv | 31 +++
 rtl/hoop_rect_check.sv | 45 ++++
 rtl/hoop_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hoops_pkg.sv
// hoops_pkg: shared types and constants for the hoop pipeline.
//   hoop_state_t   : hoop lifecycle state (WAIT, FLY, CLEARED)
//   HOOP_WIDTH/HEIGHT : on-screen hoop rectangle size in pixels
//   HOOP_MAX_SPEED : speed ceiling when the speed-up feature is built in
//   BITMAP_SCALE   : bitmap pixels are drawn BITMAP_SCALE x BITMAP_SCALE
//   clamp_y()      : clamps a random Y into the legal spawn band
package hoops_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        FLY     = 2'd1,
        CLEARED = 2'd2
    } hoop_state_t;

    localparam int HOOP_WIDTH     = 48;
    localparam int HOOP_HEIGHT    = 48;
    localparam int HOOP_MAX_SPEED = 8;
    localparam int BITMAP_SCALE   = 2;

    function automatic logic [10:0] clamp_y(input logic [10:0] val,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/hoop_rect_check.sv
// hoop_rect_check: combinational bounds check of a pixel against the hoop rectangle.
//   pixel_x_i/pixel_y_i     : current pixel coordinate (unsigned)
//   top_left_x_i            : hoop left edge, signed so it may sit off the left of screen
//   top_left_y_i            : hoop top edge (unsigned)
//   active_i                : hoop is on screen (state != WAIT)
//   inside_o                : pixel lies inside the rectangle
//   offset_x_o/offset_y_o   : raw pixel offsets from the top-left corner; only
//                             meaningful when inside_o is set
module hoop_rect_check #(
    parameter int HoopW = hoops_pkg::HOOP_WIDTH,
    parameter int HoopH = hoops_pkg::HOOP_HEIGHT
) (
    input  logic               [10:0] pixel_x_i,
    input  logic               [10:0] pixel_y_i,
    input  logic signed        [11:0] top_left_x_i,
    input  logic               [10:0] top_left_y_i,
    input  logic                      active_i,
    output logic                      inside_o,
    output logic               [10:0] offset_x_o,
    output logic               [10:0] offset_y_o
);

    localparam logic signed [11:0] HoopWS = 12'(HoopW);
    localparam logic signed [11:0] HoopHS = 12'(HoopH);

    logic signed [11:0] px;
    logic signed [11:0] py;
    logic signed [11:0] ty;
    logic signed [11:0] right_x;
    logic signed [11:0] bottom_y;

    always_comb begin
        px       = $signed({1'b0, pixel_x_i});
        py       = $signed({1'b0, pixel_y_i});
        ty       = $signed({1'b0, top_left_y_i});
        right_x  = top_left_x_i + HoopWS;
        bottom_y = ty + HoopHS;
        inside_o = active_i && (px >= top_left_x_i) && (px < right_x) &&
                   (py >= ty) && (py < bottom_y);
        // Low 11 bits of the 12-bit difference; never negative when inside.
        offset_x_o = pixel_x_i - top_left_x_i[10:0];
        offset_y_o = pixel_y_i - top_left_y_i;
    end

endmodule

// File: rtl/hoop_controller.sv
// hoop_controller: lifecycle of a single hoop plus its registered pixel path.
//   clk, resetN      : pixel clock, asynchronous active-low reset
//   startOfFrame     : one-cycle pulse per frame; all motion happens on it
//   enable           : game running; low freezes state, position and counters
//   pixelX/pixelY    : current pixel coordinate
//   randY            : random Y, sampled and clamped at spawn
//   hoopCollision    : player crossing the hoop centre
//   offsetX/offsetY  : registered pixel offset inside the hoop (0 when outside)
//   insideRectangle  : registered "pixel is inside the hoop"
//   hoopPassed       : one-cycle pulse per scored pass
//   hoopActive       : hoop is on screen (FLY or CLEARED)
// Build option: define HOOP_SPEEDUP_EN to add 1 to the speed on every scored
// pass, saturating at HOOP_MAX_SPEED.
module hoop_controller #(
    parameter int SCREEN_WIDTH = 640,
    parameter int HOOP_WIDTH   = hoops_pkg::HOOP_WIDTH,
    parameter int HOOP_HEIGHT  = hoops_pkg::HOOP_HEIGHT,
    parameter int SPEED        = 2,
    parameter int SPAWN_DELAY  = 60,
    parameter int Y_MIN        = 48,
    parameter int Y_MAX        = 384
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] randY,
    input  logic        hoopCollision,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        insideRectangle,
    output logic        hoopPassed,
    output logic        hoopActive
);

    import hoops_pkg::*;

    localparam logic signed [11:0] SpawnX     = 12'(SCREEN_WIDTH);
    localparam logic signed [11:0] HoopWS     = 12'(HOOP_WIDTH);
    localparam logic        [10:0] YMin       = 11'(Y_MIN);
    localparam logic        [10:0] YMax       = 11'(Y_MAX);
    localparam logic        [10:0] DelayInit  = 11'(SPAWN_DELAY);
    localparam logic        [3:0]  SpeedInit  = 4'(SPEED);

    hoop_state_t        state_q, state_d;
    logic        [10:0] delay_cnt_q, delay_cnt_d;
    logic signed [11:0] top_left_x_q, top_left_x_d;
    logic        [10:0] top_left_y_q, top_left_y_d;
    logic        [3:0]  speed_q, speed_d;
    logic               hoop_passed_q, hoop_passed_d;

    logic signed [11:0] moved_x;
    logic signed [11:0] moved_right;

    always_comb begin
        state_d       = state_q;
        delay_cnt_d   = delay_cnt_q;
        top_left_x_d  = top_left_x_q;
        top_left_y_d  = top_left_y_q;
        speed_d       = speed_q;
        hoop_passed_d = 1'b0;
        moved_x       = top_left_x_q - $signed({8'd0, speed_q});
        moved_right   = moved_x + HoopWS;

        if (enable) begin
            case (state_q)
                WAIT: begin
                    if (startOfFrame) begin
                        if (delay_cnt_q == 11'd0) begin
                            top_left_x_d = SpawnX;
                            top_left_y_d = clamp_y(randY, YMin, YMax);
                            state_d      = FLY;
                        end else begin
                            delay_cnt_d = delay_cnt_q - 11'd1;
                        end
                    end
                end
                FLY, CLEARED: begin
                    // Only FLY scores; CLEARED ignores collisions so a hoop scores once.
                    if (state_q == FLY && hoopCollision) begin
                        hoop_passed_d = 1'b1;
                        state_d       = CLEARED;
                    end
                    if (startOfFrame) begin
                        top_left_x_d = moved_x;
                        // Leaving the screen wins over a same-cycle pass transition.
                        if (moved_right <= 12'sd0) begin
                            state_d     = WAIT;
                            delay_cnt_d = DelayInit;
                        end
                    end
                end
                default: state_d = WAIT;
            endcase
        end

`ifdef HOOP_SPEEDUP_EN
        // Move above used speed_q, so the bump takes effect from the next frame.
        if (hoop_passed_d && (speed_q < 4'(HOOP_MAX_SPEED))) begin
            speed_d = speed_q + 4'd1;
        end
`else
        speed_d = speed_q;
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= WAIT;
            delay_cnt_q   <= DelayInit;
            top_left_x_q  <= SpawnX;
            top_left_y_q  <= YMin;
            speed_q       <= SpeedInit;
            hoop_passed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_cnt_q   <= delay_cnt_d;
            top_left_x_q  <= top_left_x_d;
            top_left_y_q  <= top_left_y_d;
            speed_q       <= speed_d;
            hoop_passed_q <= hoop_passed_d;
        end
    end

    // Pixel path: keeps running while frozen so a paused hoop stays drawn.
    logic        rect_inside;
    logic [10:0] rect_off_x;
    logic [10:0] rect_off_y;
    logic        inside_q, inside_d;
    logic [10:0] offset_x_q, offset_x_d;
    logic [10:0] offset_y_q, offset_y_d;

    hoop_rect_check #(
        .HoopW (HOOP_WIDTH),
        .HoopH (HOOP_HEIGHT)
    ) u_rect_check (
        .pixel_x_i    (pixelX),
        .pixel_y_i    (pixelY),
        .top_left_x_i (top_left_x_q),
        .top_left_y_i (top_left_y_q),
        .active_i     (state_q != WAIT),
        .inside_o     (rect_inside),
        .offset_x_o   (rect_off_x),
        .offset_y_o   (rect_off_y)
    );

    always_comb begin
        inside_d   = rect_inside;
        offset_x_d = rect_inside ? rect_off_x : 11'd0;
        offset_y_d = rect_inside ? rect_off_y : 11'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inside_q   <= 1'b0;
            offset_x_q <= 11'd0;
            offset_y_q <= 11'd0;
        end else begin
            inside_q   <= inside_d;
            offset_x_q <= offset_x_d;
            offset_y_q <= offset_y_d;
        end
    end

    assign insideRectangle = inside_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign hoopPassed      = hoop_passed_q;
    assign hoopActive      = (state_q != WAIT);

endmodule
